ecc_dec_ctrl: RTL and testbench

ECC_DEC_CTRL -- requirements
Module: ecc_dec_ctrl

---
 rtl/ecc_dec_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ecc_dec_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_dec_ctrl.sv
// ecc_dec_ctrl: sequences one received codeword at a time through the
// syndrome stage and, when a single error is reported, the error-fix stage.
// Each awaited stage gets a bounded wait. The result is held until the
// consumer takes it. Saturating counters track corrected words and failed
// words (uncorrectable or timed out).
module ecc_dec_ctrl #(
  parameter int AMBA_WORD = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           cfg_mode,
  input  logic                 in_valid,
  input  logic [AMBA_WORD-1:0] in_data,
  output logic                 in_ready,
  output logic                 syn_start,
  output logic [AMBA_WORD-1:0] syn_data,
  input  logic                 syn_done,
  input  logic [1:0]           syn_nof,
  output logic                 fix_en,
  output logic                 fix_small,
  output logic                 fix_medium,
  input  logic                 fix_done,
  input  logic [AMBA_WORD-1:0] fix_data,
  output logic                 out_valid,
  output logic [AMBA_WORD-1:0] out_data,
  output logic [1:0]           out_nof,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [15:0]          corr_cnt,
  output logic [15:0]          uncorr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYN  = 2'd1,
    FIX  = 2'd2,
    OUT  = 2'd3
  } state_e;

  localparam logic [1:0] NOF_CLEAN   = 2'b00;
  localparam logic [1:0] NOF_CORR    = 2'b01;
  localparam logic [1:0] NOF_UNCORR  = 2'b10;
  localparam logic [1:0] NOF_TIMEOUT = 2'b11;

  // The last wait cycle: a done seen in this cycle still takes the normal branch.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e               state_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 syn_start_q;
  logic [AMBA_WORD-1:0] data_q;
  logic                 fix_en_q;
  logic                 fix_small_q;
  logic                 fix_medium_q;
  logic                 out_valid_q;
  logic [AMBA_WORD-1:0] out_data_q;
  logic [1:0]           out_nof_q;
  logic [7:0]           wait_q;
  logic [15:0]          corr_q, corr_d;
  logic [15:0]          uncorr_q, uncorr_d;

  logic timeout;
  logic out_hs;

  assign timeout = (wait_q == WAIT_LAST);
  assign out_hs  = out_valid_q && out_ready;

  // Control FSM. All handshake and mode outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      syn_start_q  <= 1'b0;
      data_q       <= '0;
      fix_en_q     <= 1'b0;
      fix_small_q  <= 1'b0;
      fix_medium_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_nof_q    <= NOF_CLEAN;
      wait_q       <= '0;
    end else begin
      syn_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q       <= in_data;
            fix_small_q  <= (cfg_mode == 2'b01);
            fix_medium_q <= (cfg_mode == 2'b10);
            syn_start_q  <= 1'b1;
            wait_q       <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= SYN;
          end
        end
        SYN: begin
          if (syn_done) begin
            if (syn_nof == NOF_CORR) begin
              fix_en_q <= 1'b1;
              wait_q   <= '0;
              state_q  <= FIX;
            end else begin
              out_valid_q <= 1'b1;
              out_data_q  <= data_q;
              out_nof_q   <= (syn_nof == NOF_CLEAN) ? NOF_CLEAN : NOF_UNCORR;
              state_q     <= OUT;
            end
          end else if (timeout) begin
            out_valid_q <= 1'b1;
            out_data_q  <= data_q;
            out_nof_q   <= NOF_TIMEOUT;
            state_q     <= OUT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        FIX: begin
          if (fix_done) begin
            fix_en_q    <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= fix_data;
            out_nof_q   <= NOF_CORR;
            state_q     <= OUT;
          end else if (timeout) begin
            fix_en_q    <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= data_q;
            out_nof_q   <= NOF_TIMEOUT;
            state_q     <= OUT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            fix_small_q  <= 1'b0;
            fix_medium_q <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating statistics, advanced on the result handshake only.
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (out_hs) begin
      if (out_nof_q == NOF_CORR) begin
        if (corr_q != 16'hFFFF) corr_d = corr_q + 16'd1;
      end else if (out_nof_q[1]) begin
        if (uncorr_q != 16'hFFFF) uncorr_d = uncorr_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign syn_start  = syn_start_q;
  assign syn_data   = data_q;
  assign fix_en     = fix_en_q;
  assign fix_small  = fix_small_q;
  assign fix_medium = fix_medium_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_nof    = out_nof_q;
  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;

endmodule

// File: tb/tb_ecc_dec_ctrl.sv
// Bench for ecc_dec_ctrl. Inputs are driven 1 time unit after the rising edge.
// A negedge monitor pops the scoreboard and compares on every result handshake.
module tb_ecc_dec_ctrl;
  localparam int W  = 32;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         syn_start;
  logic [W-1:0] syn_data;
  logic         syn_done = 1'b0;
  logic [1:0]   syn_nof = 2'b00;
  logic         fix_en, fix_small, fix_medium;
  logic         fix_done = 1'b0;
  logic [W-1:0] fix_data = '0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_nof;
  logic         out_ready = 1'b0;
  logic         busy;
  logic [15:0]  corr_cnt, uncorr_cnt;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;
  int exp_corr = 0;
  int exp_uncorr = 0;

  ecc_dec_ctrl #(.AMBA_WORD(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .syn_start(syn_start),
    .syn_data(syn_data), .syn_done(syn_done), .syn_nof(syn_nof),
    .fix_en(fix_en), .fix_small(fix_small), .fix_medium(fix_medium),
    .fix_done(fix_done), .fix_data(fix_data), .out_valid(out_valid),
    .out_data(out_data), .out_nof(out_nof), .out_ready(out_ready),
    .busy(busy), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: a handshake happens on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got data=%h nof=%b, expected no output", out_data, out_nof);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_data, out_nof} !== mon_e) begin
          errors++;
          $display("FAIL scoreboard_out: got data=%h nof=%b, expected data=%h nof=%b",
                   out_data, out_nof, mon_e[33:2], mon_e[1:0]);
        end
        if (mon_e[1:0] == 2'b01) begin
          if (exp_corr < 65535) exp_corr++;
        end else if (mon_e[1]) begin
          if (exp_uncorr < 65535) exp_uncorr++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and wait for it to be taken; afterwards cfg_mode is changed.
  task automatic send(input logic [W-1:0] d, input logic [1:0] m);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; cfg_mode = m;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0; in_data = ~d;
    cfg_mode = (m == 2'b01) ? 2'b10 : 2'b01;
    checks++;
    if (syn_start !== 1'b1 || syn_data !== d) begin
      errors++;
      $display("FAIL send_accept: got syn_start=%b syn_data=%h, expected 1 %h", syn_start, syn_data, d);
    end
  endtask

  task automatic syn_reply(input int waitc, input logic [1:0] nof);
    repeat (waitc) tick();
    syn_done = 1'b1; syn_nof = nof;
    tick();
    syn_done = 1'b0; syn_nof = 2'b00;
  endtask

  task automatic fix_reply(input int waitc, input logic [W-1:0] d);
    repeat (waitc) tick();
    fix_done = 1'b1; fix_data = d;
    tick();
    fix_done = 1'b0; fix_data = '0;
  endtask

  // Wait for a result, hold off for 'hold' cycles, then take it.
  task automatic take_out(input int hold);
    int n;
    logic [W-1:0] d0;
    logic [1:0]   nf0;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL out_wait: got out_valid=0 after %0d cycles, expected 1", n);
    end
    d0 = out_data; nf0 = out_nof;
    repeat (hold) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== d0 || out_nof !== nf0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL out_hold: got v=%b d=%h nof=%b rdy=%b, expected 1 %h %b 0",
                 out_valid, out_data, out_nof, in_ready, d0, nf0);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if ({out_valid, syn_start, fix_en, fix_small, fix_medium, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {out_valid, syn_start, fix_en, fix_small, fix_medium, busy});
    end
    checks++;
    if (out_data !== '0 || out_nof !== 2'b00 || syn_data !== '0) begin
      errors++; $display("FAIL reset_data: got %h %b %h expected zeros", out_data, out_nof, syn_data);
    end
    checks++;
    if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %h %h expected 0 0", corr_cnt, uncorr_cnt);
    end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_clean();
    exp_q.push_back({32'hA5A5_0001, 2'b00});
    send(32'hA5A5_0001, 2'b11);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || fix_small !== 1'b0 || fix_medium !== 1'b0) begin
      errors++; $display("FAIL clean_busy: got rdy=%b busy=%b s=%b m=%b expected 0 1 0 0", in_ready, busy, fix_small, fix_medium);
    end
    syn_reply(3, 2'b00);
    take_out(0);
    checks++;
    if (corr_cnt !== 16'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL clean_after: got corr=%0d rdy=%b busy=%b expected 0 1 0", corr_cnt, in_ready, busy);
    end
  endtask

  task automatic test_min_latency();
    exp_q.push_back({32'h0000_1111, 2'b00});
    send(32'h0000_1111, 2'b11);
    syn_reply(0, 2'b00);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL min_latency: got out_valid=%b expected 1", out_valid); end
    take_out(0);
  endtask

  task automatic test_small_fix();
    exp_q.push_back({32'h0000_00F0, 2'b01});
    send(32'h1234_5678, 2'b01);
    syn_reply(1, 2'b01);
    repeat (3) begin
      checks++;
      if (fix_en !== 1'b1 || fix_small !== 1'b1 || fix_medium !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL small_fix_hold: got en=%b s=%b m=%b v=%b expected 1 1 0 0", fix_en, fix_small, fix_medium, out_valid);
      end
      tick();
    end
    fix_done = 1'b1; fix_data = 32'h0000_00F0;
    checks++;
    if (fix_en !== 1'b1) begin errors++; $display("FAIL small_fix_en: got %b expected 1", fix_en); end
    tick();
    fix_done = 1'b0; fix_data = '0;
    checks++;
    if (out_valid !== 1'b1 || fix_en !== 1'b0 || fix_small !== 1'b1) begin
      errors++; $display("FAIL small_fix_out: got v=%b en=%b s=%b expected 1 0 1", out_valid, fix_en, fix_small);
    end
    take_out(0);
    checks++;
    if (corr_cnt !== 16'(exp_corr) || corr_cnt !== 16'd1 || fix_small !== 1'b0) begin
      errors++; $display("FAIL small_fix_cnt: got corr=%0d s=%b expected 1 0", corr_cnt, fix_small);
    end
  endtask

  task automatic test_medium_fix();
    exp_q.push_back({32'hDEAD_BEEF, 2'b01});
    send(32'hDEAD_BEE0, 2'b10);
    checks++;
    if (fix_medium !== 1'b1 || fix_small !== 1'b0) begin
      errors++; $display("FAIL medium_mode: got s=%b m=%b expected 0 1", fix_small, fix_medium);
    end
    syn_reply(0, 2'b01);
    fix_reply(0, 32'hDEAD_BEEF);
    take_out(0);
    checks++;
    if (corr_cnt !== 16'(exp_corr)) begin errors++; $display("FAIL medium_cnt: got %0d expected %0d", corr_cnt, exp_corr); end
  endtask

  task automatic test_uncorr();
    logic [1:0] nofs [2];
    nofs[0] = 2'b10; nofs[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({32'hC0DE_0010 + 32'(k), 2'b10});
      send(32'hC0DE_0010 + 32'(k), 2'b01);
      repeat (2) begin
        checks++;
        if (fix_en !== 1'b0) begin errors++; $display("FAIL uncorr_fix_en: got %b expected 0", fix_en); end
        tick();
      end
      syn_reply(0, nofs[k]);
      checks++;
      if (fix_en !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL uncorr_branch: got en=%b v=%b expected 0 1", fix_en, out_valid);
      end
      take_out(0);
      checks++;
      if (uncorr_cnt !== 16'(exp_uncorr) || uncorr_cnt !== 16'(k + 1)) begin
        errors++; $display("FAIL uncorr_cnt: got %0d expected %0d", uncorr_cnt, k + 1);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    // No syn_done: with the syn_start cycle counted as the first, out_valid
    // shows in the 16th cycle, i.e. 15 edges after acceptance.
    exp_q.push_back({32'h7777_0001, 2'b11});
    send(32'h7777_0001, 2'b11);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    checks++;
    if (n != TO) begin errors++; $display("FAIL syn_timeout_cycles: got %0d expected %0d", n, TO); end
    syn_done = 1'b1; syn_nof = 2'b00;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_nof !== 2'b11) begin
      errors++; $display("FAIL late_syn_done: got v=%b nof=%b expected 1 11", out_valid, out_nof);
    end
    syn_done = 1'b0;
    take_out(0);
    syn_done = 1'b1; fix_done = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || fix_en !== 1'b0) begin
      errors++; $display("FAIL idle_done_ignored: got busy=%b v=%b en=%b expected 0 0 0", busy, out_valid, fix_en);
    end
    syn_done = 1'b0; fix_done = 1'b0;
    // Timeout while waiting for fix_done returns the latched word.
    exp_q.push_back({32'h7777_0002, 2'b11});
    send(32'h7777_0002, 2'b01);
    syn_reply(0, 2'b01);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    checks++;
    if (n != TO) begin errors++; $display("FAIL fix_timeout_cycles: got %0d expected %0d", n, TO); end
    take_out(0);
    // A done in the last allowed cycle wins over the timeout.
    exp_q.push_back({32'h7777_0003, 2'b00});
    send(32'h7777_0003, 2'b11);
    syn_reply(TO - 1, 2'b00);
    take_out(0);
    checks++;
    if (uncorr_cnt !== 16'(exp_uncorr)) begin errors++; $display("FAIL timeout_cnt: got %0d expected %0d", uncorr_cnt, exp_uncorr); end
  endtask

  task automatic test_backpressure();
    exp_q.push_back({32'h0BAD_F00D, 2'b00});
    send(32'h0BAD_F00D, 2'b11);
    syn_reply(0, 2'b00);
    in_valid = 1'b1; in_data = 32'h1111_2222;
    take_out(5);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || syn_start !== 1'b0 || syn_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL backpressure_accept: got busy=%b start=%b syn_data=%h expected 0 0 0badf00d", busy, syn_start, syn_data);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back({32'hB1B1_B1B1, 2'b00});
    send(32'hB1B1_B1B1, 2'b11);
    syn_reply(0, 2'b00);
    exp_q.push_back({32'hB2B2_B2B2, 2'b00});
    in_valid = 1'b1; in_data = 32'hB2B2_B2B2; cfg_mode = 2'b11;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || syn_start !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: got rdy=%b busy=%b start=%b expected 1 0 0", in_ready, busy, syn_start);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (syn_start !== 1'b1 || syn_data !== 32'hB2B2_B2B2) begin
      errors++; $display("FAIL b2b_accept: got start=%b data=%h expected 1 b2b2b2b2", syn_start, syn_data);
    end
    syn_reply(0, 2'b00);
    take_out(0);
  endtask

  task automatic test_reset_mid();
    send(32'h5555_AAAA, 2'b01);
    syn_reply(0, 2'b01);
    checks++;
    if (fix_en !== 1'b1) begin errors++; $display("FAIL mid_fix_en: got %b expected 1", fix_en); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || {fix_en, fix_small, out_valid, busy} !== 4'b0 || syn_data !== '0) begin
      errors++; $display("FAIL mid_reset: got rdy=%b flags=%b data=%h expected 1 0000 0",
                         in_ready, {fix_en, fix_small, out_valid, busy}, syn_data);
    end
    checks++;
    if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset_cnt: got %0d %0d expected 0 0", corr_cnt, uncorr_cnt);
    end
    exp_q.delete(); exp_corr = 0; exp_uncorr = 0;
    @(negedge clk) rst = 1'b0;
    fix_done = 1'b1; fix_data = 32'hFFFF_0000; syn_done = 1'b1; syn_nof = 2'b01;
    repeat (3) begin
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || fix_en !== 1'b0) begin
        errors++; $display("FAIL post_reset_done: got busy=%b v=%b en=%b expected 0 0 0", busy, out_valid, fix_en);
      end
    end
    fix_done = 1'b0; syn_done = 1'b0; syn_nof = 2'b00;
    exp_q.push_back({32'hF0F0_0F0F, 2'b01});
    send(32'hAAAA_0000, 2'b10);
    syn_reply(0, 2'b01);
    fix_reply(1, 32'hF0F0_0F0F);
    take_out(0);
    checks++;
    if (corr_cnt !== 16'd1) begin errors++; $display("FAIL post_reset_word: got corr=%0d expected 1", corr_cnt); end
    // Preload near saturation, then push past it.
    @(negedge clk) force dut.corr_q = 16'hFFFE;
    @(negedge clk) release dut.corr_q;
    exp_corr = 65534;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({32'h0000_0100 + 32'(k), 2'b01});
      send(32'h0000_0000, 2'b11);
      syn_reply(0, 2'b01);
      fix_reply(0, 32'h0000_0100 + 32'(k));
      take_out(0);
      checks++;
      if (corr_cnt !== 16'hFFFF) begin errors++; $display("FAIL corr_saturate: got %h expected ffff", corr_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_min_latency();
    test_small_fix();
    test_medium_fix();
    test_uncorr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d pending expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
